// File: rtl/gol_seed_sequencer.sv
// Seed sequencer for a Game-of-Life cell array: shifts in a serial seed, pulses
// the array's load, then issues genCount step pulses spaced STEP_INTERVAL cycles apart.
module gol_seed_sequencer #(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int STEP_INTERVAL = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   seedBit,
    input  logic                   seedValid,
    output logic                   seedReady,
    input  logic [7:0]             genCount,
    input  logic                   abort,
    output logic [ROWS*COLS-1:0]   initialState,
    output logic                   cellLoad,
    output logic                   cellStep,
    output logic [7:0]             genIndex,
    output logic                   busy,
    output logic                   done
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

    typedef enum logic [1:0] {LOAD, PRESET, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] bit_idx;
    logic [CW-1:0] cnt;
    logic [7:0]    target;
    logic          accept, last_bit, step_hit;

    assign accept   = (state == LOAD) && seedValid;
    assign last_bit = (bit_idx == IW'(N - 1));
    assign step_hit = (cnt == CW'(STEP_INTERVAL - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= LOAD;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        seedReady = 1'b0;
        cellLoad  = 1'b0;
        cellStep  = 1'b0;
        done      = 1'b0;
        busy      = (state != LOAD);
        case (state)
            LOAD: begin
                seedReady = 1'b1;
                if (accept && last_bit) state_nxt = PRESET;
            end
            PRESET: begin
                cellLoad  = 1'b1;
                // genCount is being latched on this same edge, so it equals the target
                state_nxt = (genCount == 8'd0) ? DONE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = LOAD;
                end else if (step_hit) begin
                    cellStep = 1'b1;
                    if (8'(genIndex + 8'd1) == target) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bit_idx      <= '0;
            initialState <= '0;
            genIndex     <= 8'd0;
            target       <= 8'd0;
            cnt          <= '0;
        end else begin
            if (accept) begin
                initialState[bit_idx] <= seedBit;
                bit_idx               <= last_bit ? '0 : bit_idx + IW'(1);
            end
            if (state == PRESET) begin
                target   <= genCount;
                genIndex <= 8'd0;
                cnt      <= '0;
            end
            // an aborted cycle neither steps nor advances the interval
            if (state == RUN && !abort) begin
                if (step_hit) begin
                    cnt      <= '0;
                    genIndex <= genIndex + 8'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gol_seed_sequencer.sv
// Bench for gol_seed_sequencer: directed and randomized loads/runs on a default
// instance, plus a STEP_INTERVAL=1 instance for the back-to-back step case.
module tb_gol_seed_sequencer;
    localparam int SI = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        seedBit = 1'b0, seedValid = 1'b0, abort = 1'b0;
    logic [7:0]  genCount = 8'd0;
    logic        seedReady, cellLoad, cellStep, busy, done;
    logic [63:0] initialState;
    logic [7:0]  genIndex;

    logic        seedBit_b = 1'b0, seedValid_b = 1'b0, abort_b = 1'b0;
    logic [7:0]  genCount_b = 8'd0;
    logic        seedReady_b, cellLoad_b, cellStep_b, busy_b, done_b;
    logic [63:0] initialState_b;
    logic [7:0]  genIndex_b;

    int errors = 0;
    int checks = 0;

    gol_seed_sequencer dut (
        .clk(clk), .resetN(resetN), .seedBit(seedBit), .seedValid(seedValid),
        .seedReady(seedReady), .genCount(genCount), .abort(abort),
        .initialState(initialState), .cellLoad(cellLoad), .cellStep(cellStep),
        .genIndex(genIndex), .busy(busy), .done(done)
    );

    gol_seed_sequencer #(.ROWS(8), .COLS(8), .STEP_INTERVAL(1)) dut_b (
        .clk(clk), .resetN(resetN), .seedBit(seedBit_b), .seedValid(seedValid_b),
        .seedReady(seedReady_b), .genCount(genCount_b), .abort(abort_b),
        .initialState(initialState_b), .cellLoad(cellLoad_b), .cellStep(cellStep_b),
        .genIndex(genIndex_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".seedReady"}, 64'(seedReady), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".pulses"}, 64'({cellLoad, cellStep, done}), 64'd0);
        chk({tag, ".genIndex"}, 64'(genIndex), 64'd0);
        chk({tag, ".initialState"}, initialState, 64'd0);
    endtask

    // Shift in 64 bits, LSB first; abort toggles randomly since LOAD must ignore it.
    task automatic load_a(input string tag, input logic [63:0] bits);
        for (int i = 0; i < 64; i++) begin
            seedValid = 1'b1;
            seedBit   = bits[i];
            abort     = 1'($urandom_range(0, 1));
            tick();
        end
        seedValid = 1'b0;
        abort     = 1'b0;
        chk({tag, ".cellLoad"}, 64'(cellLoad), 64'd1);
        chk({tag, ".initialState"}, initialState, bits);
    endtask

    // Entered while observing the PRESET cycle. RUN cycle c (1-based) steps when
    // c is a multiple of SI up to gc*SI; done follows in cycle gc*SI+1.
    // abort_cyc > 0 raises abort during that RUN cycle.
    task automatic run_a(input string tag, input int gc, input int abort_cyc,
                         input logic [63:0] bits);
        int last;
        int bad;
        last = gc * SI + 1;
        bad  = 0;
        chk({tag, ".presetBusy"}, 64'({busy, seedReady}), 64'b10);
        abort = 1'($urandom_range(0, 1));
        for (int c = 1; c <= last; c++) begin
            logic exp_step, exp_done;
            tick();
            abort     = 1'b0;
            genCount  = 8'($urandom);
            seedValid = 1'($urandom_range(0, 1));
            seedBit   = 1'($urandom_range(0, 1));
            if (c == abort_cyc) begin
                abort = 1'b1;
                #1;
                chk({tag, ".abortNoStep"}, 64'({cellStep, done}), 64'd0);
                tick();
                abort     = 1'b0;
                seedValid = 1'b0;
                chk({tag, ".abortLoad"}, 64'({seedReady, busy}), 64'b10);
                chk({tag, ".abortGenIndex"}, 64'(genIndex), 64'((c - 1) / SI));
                chk({tag, ".abortState"}, initialState, bits);
                tick();
                chk({tag, ".abortNoDone"}, 64'(done), 64'd0);
                return;
            end
            exp_step = (c % SI == 0) && (c <= gc * SI);
            exp_done = (c == last);
            if (cellStep !== exp_step || done !== exp_done || cellLoad !== 1'b0) bad++;
            if (exp_done) abort = 1'($urandom_range(0, 1));
        end
        chk({tag, ".pulseTimeline"}, 64'(bad), 64'd0);
        tick();
        abort     = 1'b0;
        seedValid = 1'b0;
        chk({tag, ".endLoad"}, 64'({seedReady, busy, done}), 64'b100);
        chk({tag, ".genIndex"}, 64'(genIndex), 64'(gc));
        chk({tag, ".stateHeld"}, initialState, bits);
    endtask

    initial begin
        logic [63:0] bits;
        int k;
        int steps;

        // Reset state
        #2;
        chk_reset_outputs("rst");
        chk("rst.b", 64'({seedReady_b, busy_b, cellLoad_b, cellStep_b, done_b}), 64'b10000);
        tick();
        #2 resetN = 1'b1;
        tick();

        // Alternating 1,0 seed, three generations
        load_a("alt", 64'h5555_5555_5555_5555);
        genCount = 8'd3;
        // genCount must be valid in PRESET; it is sampled on the edge leaving it
        run_a("alt", 3, 0, 64'h5555_5555_5555_5555);

        // Zero generations: done directly after cellLoad
        bits = {$urandom, $urandom};
        load_a("zero", bits);
        genCount = 8'd0;
        run_a("zero", 0, 0, bits);

        // Random seeds and generation counts
        for (int r = 0; r < 4; r++) begin
            int gc;
            gc   = $urandom_range(1, 6);
            bits = {$urandom, $urandom};
            load_a("rand", bits);
            genCount = 8'(gc);
            run_a("rand", gc, 0, bits);
        end

        // seedValid toggling: 64 accepts take 127 cycles
        bits = {$urandom, $urandom};
        k = 0;
        while (seedReady && k < 200) begin
            seedValid = (k % 2 == 0);
            seedBit   = bits[k / 2];
            tick();
            k++;
        end
        seedValid = 1'b0;
        chk("toggle.cycles", 64'(k), 64'd127);
        chk("toggle.cellLoad", 64'(cellLoad), 64'd1);
        chk("toggle.initialState", initialState, bits);
        genCount = 8'd2;
        run_a("toggle", 2, 0, bits);

        // Abort after the second step
        bits = {$urandom, $urandom};
        load_a("abort1", bits);
        genCount = 8'd5;
        run_a("abort1", 5, 2 * SI + 1, bits);

        // Abort landing on a step cycle suppresses that step
        bits = {$urandom, $urandom};
        load_a("abort2", bits);
        genCount = 8'd5;
        run_a("abort2", 5, 3 * SI, bits);

        // Reset mid-load discards the partial load
        for (int i = 0; i < 10; i++) begin
            seedValid = 1'b1;
            seedBit   = 1'b1;
            tick();
        end
        #2 resetN = 1'b0;
        #1 chk_reset_outputs("midrst");
        seedValid = 1'b0;
        tick();
        chk_reset_outputs("midrst.held");
        #2 resetN = 1'b1;
        tick();
        bits = {$urandom, $urandom};
        load_a("postrst", bits);
        genCount = 8'd1;
        run_a("postrst", 1, 0, bits);

        // STEP_INTERVAL=1 instance: 255 back-to-back steps
        bits = {$urandom, $urandom};
        for (int i = 0; i < 64; i++) begin
            seedValid_b = 1'b1;
            seedBit_b   = bits[i];
            tick();
        end
        seedValid_b = 1'b0;
        genCount_b  = 8'd255;
        chk("si1.cellLoad", 64'(cellLoad_b), 64'd1);
        chk("si1.initialState", initialState_b, bits);
        steps = 0;
        for (int c = 1; c <= 255; c++) begin
            tick();
            genCount_b = 8'($urandom);
            if (cellStep_b === 1'b1 && done_b === 1'b0) steps++;
        end
        chk("si1.steps", 64'(steps), 64'd255);
        tick();
        chk("si1.done", 64'({done_b, cellStep_b}), 64'b10);
        chk("si1.genIndex", 64'(genIndex_b), 64'd255);
        tick();
        chk("si1.endLoad", 64'({seedReady_b, busy_b}), 64'b10);
        chk("si1.genHeld", 64'(genIndex_b), 64'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gol_seed_sequencer.md
GOL_SEED_SEQUENCER -- requirements
Module: gol_seed_sequencer

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, grid height in cells.
REQ-002 The block SHALL have parameter COLS, default 8, grid width in cells; N = ROWS*COLS.
REQ-003 The block SHALL have parameter STEP_INTERVAL, default 4, clock cycles per generation (legal values >= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port seedBit, input, 1 bit: serial seed data.
REQ-007 The block SHALL have port seedValid, input, 1 bit: seedBit is valid.
REQ-008 The block SHALL have port seedReady, output, 1 bit: block accepts a seed bit.
REQ-009 The block SHALL have port genCount, input, 8 bits: number of generations to run.
REQ-010 The block SHALL have port abort, input, 1 bit: terminates a run.
REQ-011 The block SHALL have port initialState, output, N bits: seed pattern driven to the cell array, bit r*COLS+c for cell (r,c).
REQ-012 The block SHALL have port cellLoad, output, 1 bit: one-cycle pulse; cells take initialState.
REQ-013 The block SHALL have port cellStep, output, 1 bit: one-cycle pulse; cells advance one generation.
REQ-014 The block SHALL have port genIndex, output, 8 bits: generations completed in the current run.
REQ-015 The block SHALL have ports busy, output, 1 bit, and done, output, 1 bit: busy high outside LOAD; done is a one-cycle end-of-run pulse.

Function
REQ-016 The FSM SHALL have states LOAD, PRESET, RUN and DONE.
REQ-017 In LOAD, seedReady SHALL be 1; in all other states it SHALL be 0.
REQ-018 A bit SHALL be accepted on a rising edge with seedValid=1 and seedReady=1 and written to initialState[bitIdx], after which bitIdx SHALL increment; the first accepted bit of a load SHALL go to index 0.
REQ-019 seedValid outside LOAD SHALL be ignored: no write, no index change.
REQ-020 Acceptance of bit N-1 SHALL move the FSM to PRESET and clear bitIdx to 0.
REQ-021 PRESET SHALL last exactly one cycle, with cellLoad=1 in that cycle.
REQ-022 In PRESET, genCount SHALL be latched into an internal target register, and genIndex and the interval counter SHALL be cleared.
REQ-023 From PRESET, the FSM SHALL go to DONE if the latched target is 0, and otherwise to RUN.
REQ-024 In RUN, the interval counter SHALL count 0..STEP_INTERVAL-1.
REQ-025 cellStep SHALL be 1 in the RUN cycle where the counter equals STEP_INTERVAL-1; on that edge the counter SHALL wrap to 0 and genIndex SHALL increment.
REQ-026 The first cellStep SHALL occur in the STEP_INTERVAL-th RUN cycle.
REQ-027 With STEP_INTERVAL=1, cellStep SHALL be asserted in every RUN cycle.
REQ-028 When the incremented genIndex equals the target, the FSM SHALL go to DONE on that edge.
REQ-029 DONE SHALL last one cycle with done=1; the next state SHALL be LOAD.
REQ-030 genIndex SHALL hold its final value until the next PRESET.
REQ-031 initialState SHALL hold its contents outside LOAD.
REQ-032 initialState SHALL NOT be cleared between loads; each load overwrites all N bits.
REQ-033 abort=1 in RUN SHALL move the FSM to LOAD on the next edge with no done pulse, and cellStep SHALL be suppressed in that cycle.
REQ-034 abort SHALL be ignored in LOAD, PRESET and DONE.
REQ-035 genCount changes after PRESET SHALL NOT affect the current run.
REQ-036 cellLoad, cellStep and done SHALL be mutually exclusive in every cycle.

Reset
REQ-037 resetN=0 SHALL immediately, without a clock edge, force state LOAD, bitIdx=0, initialState=0, genIndex=0, target=0 and interval counter=0.
REQ-038 During and after reset, seedReady SHALL be 1, and cellLoad, cellStep, done and busy SHALL be 0.
REQ-039 Reset asserted mid-load or mid-run SHALL discard partial progress; the next accepted bit SHALL go to index 0.

Verification
REQ-040 Reset, then 64 bits of alternating 1,0 with seedValid held high, genCount=3, defaults -> initialState=64'h5555_5555_5555_5555; cellLoad in the cycle after the 64th acceptance; cellStep in RUN cycles 4, 8 and 12; done one cycle later; genIndex=3.
REQ-041 Full load with genCount=0 -> cellLoad, then done in the next cycle; cellStep never asserted; genIndex=0.
REQ-042 seedValid toggled 1/0 every cycle during the load -> exactly 64 bits accepted over 127 cycles; seedValid held high while busy -> initialState unchanged.
REQ-043 genCount=5, abort pulsed after the second cellStep -> no done pulse; state back to LOAD; genIndex=2; seedReady=1.
REQ-044 resetN dropped mid-load after 10 bits, then released and a full 64-bit load performed -> first post-reset bit lands at index 0; all outputs at reset values while resetN=0.
REQ-045 STEP_INTERVAL=1, genCount=255 -> 255 consecutive cellStep cycles; genIndex=255; done in the following cycle.
